mem_model_burst_tx: RTL and testbench
=====================================

// Module: mem_model_burst_tx
// PURPOSE
//  Read-burst transmitter for the memory model. Pops burst commands {count,addr}
//  from the mem_model command queue, issues one word read per beat to the model
//  memory, and returns the data on a valid/ready stream with a last-beat marker.
//  A 2-entry output buffer with credit-based issue sustains 1 beat/cycle under
//  continuous tx_ready.
// PARAMETERS
//  ADDR_WIDTH   32  byte address width; also the queue address field width
//  BURST_WIDTH  12  burst count field width in the queue word
//  DATA_WIDTH   32  beat width; address step per beat = DATA_WIDTH/8
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  reset      in   1            asynchronous, active-high reset
//  abort      in   1            synchronous flush of the current burst
//  q_empty    in   1            command queue empty
//  q_rdata    in   ADDR+BURST   queue head: [ADDR+BURST-1:ADDR]=count, [ADDR-1:0]=addr
//  q_read     out  1            pop strobe to queue (one cycle per command)
//  mem_rd     out  1            memory read strobe
//  mem_addr   out  ADDR_WIDTH   memory byte address, valid when mem_rd
//  mem_rdata  in   DATA_WIDTH   read data, valid the cycle after mem_rd
//  tx_valid   out  1            beat valid
//  tx_data    out  DATA_WIDTH   beat data
//  tx_last    out  1            final beat of burst, qualified by tx_valid
//  tx_ready   in   1            downstream accept; beat moves when tx_valid&tx_ready
//  busy       out  1            burst active, read in flight or buffer non-empty
//  err_zero   out  1            one-cycle pulse: zero-count command discarded
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; buffer empty, nothing in flight, remaining=0.
//  FSM IDLE: if !q_empty and !abort: q_read=1 for one cycle, latch addr/count.
//   count==0 -> err_zero pulse next cycle, stay IDLE. Else -> ISSUE.
//  ISSUE: mem_rd=1 when credit available: (buf_occ + inflight - pop) < 2,
//   pop = tx_valid&tx_ready this cycle. Each issue: mem_addr=cur addr,
//   addr += DATA_WIDTH/8 (mod 2^ADDR_WIDTH), remaining -= 1. Last issue
//   (remaining==1) -> IDLE. IDLE may pop next command the following cycle
//   (one-cycle mem_rd bubble between bursts; tx stream may stay continuous).
//  Data path: mem_rd in cycle C -> mem_rdata sampled end of C+1 into buffer
//   with last flag -> tx_valid no earlier than C+2. Pop in T -> first mem_rd T+1
//   -> first tx_valid T+3.
//  Buffer: 2 entries, FIFO order; tx_data/tx_last always show head entry;
//   tx_data/tx_last hold stable while tx_valid&!tx_ready. Simultaneous write
//   and pop allowed. Credit rule guarantees no overflow; never drop a beat.
//  tx_last set only on the beat from the burst's final mem_rd.
//  busy = (FSM!=IDLE) | inflight | (buf_occ!=0).
//  abort (sync, any state): next cycle FSM=IDLE, buffer empty, tx_valid=0,
//   remaining=0, in-flight return data discarded; no q_read in abort cycle;
//   queue contents untouched.
//  reset mid-burst: immediate return to reset state; no partial beats.
//  q_read never asserted while q_empty=1 or outside IDLE.
// TESTING
//  1 count=4 addr=0x100, tx_ready=1 -> mem_addr 0x100,104,108,10C on 4 cycles;
//    4 beats back-to-back from T+3, tx_last on 4th only, busy low after.
//  2 count=3, tx_ready toggled 1/0 each cycle -> beats in order, data stable
//    while stalled, never >2 outstanding reads+buffered, 3 beats total.
//  3 count=0 then count=1 queued -> err_zero one pulse, no mem_rd for first;
//    second gives single beat with tx_last=1.
//  4 addr=0xFFFFFFFC count=2 -> mem_addr 0xFFFFFFFC then 0x00000000.
//  5 count=8, abort after 3rd accepted beat with 2 reads in flight -> tx_valid
//    0 next cycle, no further beats, next queued burst starts clean.
//  6 two bursts count=2 queued, tx_ready=1 -> pops separated by 3 cycles,
//    4 beats, tx_last on beats 2 and 4; reset asserted mid-burst -> all outputs 0.

Source files
------------

// File: rtl/mem_model_burst_tx_if.sv
// ----------------------------------------------------------------------------
// mem_model_burst_tx_if
//   Signal bundle for the memory-model read-burst transmitter: command queue
//   side, model-memory read side, and the outgoing beat stream.
//
//   master : the transmitter (pops queue, drives memory reads, sources beats)
//   slave  : the environment (queue, memory, downstream sink, abort source)
//
//   abort      synchronous flush request of the current burst
//   q_empty    command queue empty
//   q_rdata    queue head {count, addr}
//   q_read     pop strobe
//   mem_rd     memory read strobe, mem_addr valid with it
//   mem_rdata  read data, valid the cycle after mem_rd
//   tx_valid / tx_data / tx_last / tx_ready   beat stream
//   busy       burst active, read in flight or buffer non-empty
//   err_zero   one-cycle pulse on a discarded zero-count command
// ----------------------------------------------------------------------------
interface mem_model_burst_tx_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BURST_WIDTH = 12,
    parameter int DATA_WIDTH  = 32
);
    logic                              abort;
    logic                              q_empty;
    logic [ADDR_WIDTH+BURST_WIDTH-1:0] q_rdata;
    logic                              q_read;
    logic                              mem_rd;
    logic [ADDR_WIDTH-1:0]             mem_addr;
    logic [DATA_WIDTH-1:0]             mem_rdata;
    logic                              tx_valid;
    logic [DATA_WIDTH-1:0]             tx_data;
    logic                              tx_last;
    logic                              tx_ready;
    logic                              busy;
    logic                              err_zero;

    modport master (
        input  abort, q_empty, q_rdata, mem_rdata, tx_ready,
        output q_read, mem_rd, mem_addr, tx_valid, tx_data, tx_last, busy, err_zero
    );

    modport slave (
        output abort, q_empty, q_rdata, mem_rdata, tx_ready,
        input  q_read, mem_rd, mem_addr, tx_valid, tx_data, tx_last, busy, err_zero
    );
endinterface

// File: rtl/mem_model_burst_tx.sv
// ----------------------------------------------------------------------------
// mem_model_burst_tx
//   Read-burst transmitter for the memory model. Pops {count,addr} commands
//   from the command queue, issues one word read per beat to the model memory
//   and returns the read data on a valid/ready stream with a last-beat marker.
//   A 2-entry output buffer plus credit-based issue sustains one beat per
//   cycle while tx_ready stays high.
//
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    mem_model_burst_tx_if.master (queue, memory and beat-stream signals)
// ----------------------------------------------------------------------------
module mem_model_burst_tx #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BURST_WIDTH = 12,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_model_burst_tx_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [BURST_WIDTH-1:0]  remaining;
    logic                    err_zero_q;

    // read return tracking: one cycle behind mem_rd
    logic                    rd_vld_p1;
    logic                    rd_last_p1;

    // 2-entry output buffer
    logic [DATA_WIDTH-1:0]   buf_data [2];
    logic                    buf_last [2];
    logic                    buf_rd_ptr;
    logic                    buf_wr_ptr;
    logic [1:0]              buf_occ;

    logic [BURST_WIDTH-1:0]  q_count;
    logic [ADDR_WIDTH-1:0]   q_addr;
    logic                    q_pop;
    logic                    issue;
    logic                    tx_valid_int;
    logic                    pop;
    logic                    push;
    logic [2:0]              credit_sum;
    logic                    credit_ok;

    assign q_count      = bus.q_rdata[ADDR_WIDTH+BURST_WIDTH-1:ADDR_WIDTH];
    assign q_addr       = bus.q_rdata[ADDR_WIDTH-1:0];

    assign tx_valid_int = (buf_occ != 2'd0);
    assign pop          = tx_valid_int & bus.tx_ready;
    // returning data lands in the buffer unless abort discards it
    assign push         = rd_vld_p1 & ~bus.abort;

    // Slots committed after this cycle if no new read is issued. A pop can
    // only happen with buf_occ >= 1, so the subtraction never wraps.
    assign credit_sum   = 3'(buf_occ) + 3'(rd_vld_p1) - 3'(pop);
    assign credit_ok    = (credit_sum < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_pop     = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.q_empty && !bus.abort) begin
                    q_pop = 1'b1;
                    if (q_count != '0) begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (credit_ok) begin
                    issue = 1'b1;
                    if (remaining == BURST_WIDTH'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // issue stage -> return stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining  <= '0;
            err_zero_q <= 1'b0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
            buf_rd_ptr <= 1'b0;
            buf_wr_ptr <= 1'b0;
            buf_occ    <= 2'd0;
        end else begin
            err_zero_q <= q_pop && (q_count == '0);
            rd_vld_p1  <= issue;
            rd_last_p1 <= issue && (remaining == BURST_WIDTH'(1));

            if (bus.abort) begin
                remaining <= '0;
            end else if (q_pop) begin
                remaining <= q_count;
            end else if (issue) begin
                remaining <= remaining - BURST_WIDTH'(1);
            end

            if (bus.abort) begin
                buf_rd_ptr <= 1'b0;
                buf_wr_ptr <= 1'b0;
                buf_occ    <= 2'd0;
            end else begin
                if (push) begin
                    buf_wr_ptr <= ~buf_wr_ptr;
                end
                if (pop) begin
                    buf_rd_ptr <= ~buf_rd_ptr;
                end
                buf_occ <= buf_occ + 2'(push) - 2'(pop);
            end
        end
    end

    // return stage -> buffer
    always_ff @(posedge clk) begin
        if (q_pop) begin
            cur_addr <= q_addr;
        end else if (issue) begin
            cur_addr <= cur_addr + ADDR_STEP;
        end
        if (push) begin
            buf_data[buf_wr_ptr] <= bus.mem_rdata;
            buf_last[buf_wr_ptr] <= rd_last_p1;
        end
    end

    // Data-carrying outputs are forced to zero when not qualified, so the
    // unreset storage never shows on the ports.
    assign bus.q_read   = q_pop;
    assign bus.mem_rd   = issue;
    assign bus.mem_addr = issue ? cur_addr : '0;
    assign bus.tx_valid = tx_valid_int;
    assign bus.tx_data  = tx_valid_int ? buf_data[buf_rd_ptr] : '0;
    assign bus.tx_last  = tx_valid_int & buf_last[buf_rd_ptr];
    assign bus.busy     = (state != IDLE) | rd_vld_p1 | tx_valid_int;
    assign bus.err_zero = err_zero_q;

endmodule

// File: tb/tb_mem_model_burst_tx.sv
// ----------------------------------------------------------------------------
// tb_mem_model_burst_tx
//   Self-checking bench for mem_model_burst_tx. A command-queue model and a
//   model memory drive the DUT; every burst pushed expands into the expected
//   beat list (address arithmetic on a per-address data function), which the
//   beat monitor consumes in order.
// ----------------------------------------------------------------------------
module tb_mem_model_burst_tx;

    localparam int AW   = 32;
    localparam int BW   = 12;
    localparam int DW   = 32;
    localparam int STEP = DW / 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_model_burst_tx_if #(.ADDR_WIDTH(AW), .BURST_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

    mem_model_burst_tx #(.ADDR_WIDTH(AW), .BURST_WIDTH(BW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- model memory ----------------
    logic [31:0] salt;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0], a[31:16]} ^ salt;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem_word(bus.mem_addr);
    end

    // ---------------- command queue model ----------------
    logic [AW+BW-1:0] cmd_mem [64];
    logic [5:0]       q_head = 6'd0;
    logic [5:0]       q_tail = 6'd0;
    logic             q_flush = 1'b0;

    assign bus.q_empty = (q_head == q_tail);
    assign bus.q_rdata = cmd_mem[q_head];

    always @(posedge clk) begin
        if (q_flush) q_head <= q_tail;
        else if (bus.q_read && !reset) q_head <= q_head + 6'd1;
    end

    // ---------------- expected beat stream ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            id;
    } beat_t;

    beat_t exp_q[$];
    int    burst_id = 0;

    task automatic push_cmd(input logic [AW-1:0] addr, input int cnt);
        cmd_mem[q_tail] = {BW'(cnt), addr};
        q_tail = q_tail + 6'd1;
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back('{data: mem_word(addr + AW'(i * STEP)), last: (i == cnt - 1), id: burst_id});
        end
        burst_id++;
    endtask

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            pop_cyc[$];
    int            rd_cyc[$];
    logic [AW-1:0] rd_addr[$];
    int            beat_cyc[$];
    int            errz_hi = 0;
    int            outst = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] data_prev;
    logic          last_prev;
    beat_t         mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            outst      = 0;
            stall_prev = 1'b0;
        end else begin
            if (bus.q_read) pop_cyc.push_back(cyc);
            if (bus.err_zero) errz_hi++;
            if (bus.mem_rd) begin
                rd_cyc.push_back(cyc);
                rd_addr.push_back(bus.mem_addr);
            end
            if (stall_prev) begin
                chk("hold_valid", 64'(bus.tx_valid), 64'd1);
                chk("hold_data", 64'(bus.tx_data), 64'(data_prev));
                chk("hold_last", 64'(bus.tx_last), 64'(last_prev));
            end
            if (bus.tx_valid && bus.tx_ready) begin
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", 64'(bus.tx_data), 64'(mon_e.data));
                    chk("beat_last", 64'(bus.tx_last), 64'(mon_e.last));
                end
            end
            outst = outst + int'(bus.mem_rd) - int'(bus.tx_valid && bus.tx_ready);
            if (bus.mem_rd) chk("credit", 64'(outst <= 2), 64'd1);
            stall_prev = bus.tx_valid && !bus.tx_ready && !bus.abort;
            data_prev  = bus.tx_data;
            last_prev  = bus.tx_last;
            if (bus.abort) outst = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: toggle each cycle, 2: random
    task automatic run_until_idle(input int max_cyc, input int mode, input string tag);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < max_cyc) begin
            case (mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ~bus.tx_ready;
                default: bus.tx_ready = ($urandom_range(3) != 0);
            endcase
            tick();
            n++;
            done = (q_head == q_tail) && (exp_q.size() == 0) && !bus.busy;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_q_read"},   64'(bus.q_read),   64'd0);
        chk({tag, "_mem_rd"},   64'(bus.mem_rd),   64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        chk({tag, "_tx_valid"}, 64'(bus.tx_valid), 64'd0);
        chk({tag, "_tx_data"},  64'(bus.tx_data),  64'd0);
        chk({tag, "_tx_last"},  64'(bus.tx_last),  64'd0);
        chk({tag, "_busy"},     64'(bus.busy),     64'd0);
        chk({tag, "_err_zero"}, 64'(bus.err_zero), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int b_pop, b_rd, b_bt, b_ez, t0, aid, n;
        logic [AW-1:0] ra;

        salt         = $urandom;
        reset        = 1'b1;
        bus.abort    = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // 1: count=4 at 0x100, continuous ready
        bus.tx_ready = 1'b1;
        b_pop = pop_cyc.size(); b_rd = rd_cyc.size(); b_bt = beat_cyc.size();
        push_cmd(32'h100, 4);
        t0 = cyc;
        run_until_idle(50, 0, "t1");
        chk("t1_npop", 64'(pop_cyc.size() - b_pop), 64'd1);
        chk("t1_nrd", 64'(rd_cyc.size() - b_rd), 64'd4);
        chk("t1_nbeat", 64'(beat_cyc.size() - b_bt), 64'd4);
        if (pop_cyc.size() > b_pop) chk("t1_pop_cyc", 64'(pop_cyc[b_pop]), 64'(t0));
        if (rd_cyc.size() >= b_rd + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_rd_cyc", 64'(rd_cyc[b_rd+i]), 64'(t0 + 1 + i));
                chk("t1_rd_addr", 64'(rd_addr[b_rd+i]), 64'(32'h100 + i * STEP));
            end
        end
        if (beat_cyc.size() >= b_bt + 4) begin
            for (int i = 0; i < 4; i++) chk("t1_beat_cyc", 64'(beat_cyc[b_bt+i]), 64'(t0 + 3 + i));
        end
        tick();
        chk("t1_busy_after", 64'(bus.busy), 64'd0);

        // 2: count=3 with toggling ready
        b_bt = beat_cyc.size();
        push_cmd($urandom & 32'hFFFF_FFFC, 3);
        run_until_idle(60, 1, "t2");
        chk("t2_nbeat", 64'(beat_cyc.size() - b_bt), 64'd3);

        // 3: zero-count then count=1
        b_rd = rd_cyc.size(); b_ez = errz_hi; b_pop = pop_cyc.size();
        push_cmd(32'h200, 0);
        push_cmd(32'h300, 1);
        run_until_idle(50, 0, "t3");
        chk("t3_err_zero", 64'(errz_hi - b_ez), 64'd1);
        chk("t3_npop", 64'(pop_cyc.size() - b_pop), 64'd2);
        chk("t3_nrd", 64'(rd_cyc.size() - b_rd), 64'd1);
        if (rd_addr.size() > b_rd) chk("t3_rd_addr", 64'(rd_addr[b_rd]), 64'h300);

        // 4: address wrap
        b_rd = rd_cyc.size();
        push_cmd(32'hFFFF_FFFC, 2);
        run_until_idle(50, 0, "t4");
        chk("t4_nrd", 64'(rd_cyc.size() - b_rd), 64'd2);
        if (rd_addr.size() >= b_rd + 2) begin
            chk("t4_addr0", 64'(rd_addr[b_rd]), 64'hFFFF_FFFC);
            chk("t4_addr1", 64'(rd_addr[b_rd+1]), 64'h0);
        end

        // 5: abort after 3rd accepted beat of an 8-beat burst
        bus.tx_ready = 1'b1;
        b_bt = beat_cyc.size();
        aid = burst_id;
        push_cmd(32'h1000, 8);
        n = 0;
        while ((beat_cyc.size() - b_bt) < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("t5_reach3", 64'(beat_cyc.size() - b_bt), 64'd3);
        bus.tx_ready = 1'b0;
        bus.abort    = 1'b1;
        chk("t5_busy_at_abort", 64'(bus.busy), 64'd1);
        while (exp_q.size() != 0 && exp_q[0].id == aid) void'(exp_q.pop_front());
        tick();
        bus.abort    = 1'b0;
        bus.tx_ready = 1'b1;
        chk("t5_valid_after", 64'(bus.tx_valid), 64'd0);
        chk("t5_busy_after", 64'(bus.busy), 64'd0);
        b_rd = rd_cyc.size();
        repeat (6) tick();
        chk("t5_no_beats", 64'(beat_cyc.size() - b_bt), 64'd3);
        chk("t5_no_reads", 64'(rd_cyc.size() - b_rd), 64'd0);
        b_bt = beat_cyc.size();
        push_cmd(32'h2000, 2);
        run_until_idle(50, 0, "t5_next");
        chk("t5_next_nbeat", 64'(beat_cyc.size() - b_bt), 64'd2);

        // 6: two back-to-back bursts, then reset mid-burst
        b_pop = pop_cyc.size(); b_bt = beat_cyc.size();
        push_cmd(32'h400, 2);
        push_cmd(32'h500, 2);
        run_until_idle(60, 0, "t6");
        chk("t6_npop", 64'(pop_cyc.size() - b_pop), 64'd2);
        if (pop_cyc.size() >= b_pop + 2) chk("t6_pop_gap", 64'(pop_cyc[b_pop+1] - pop_cyc[b_pop]), 64'd3);
        chk("t6_nbeat", 64'(beat_cyc.size() - b_bt), 64'd4);

        push_cmd(32'h600, 8);
        repeat (5) tick();
        chk("t6_busy_pre", 64'(bus.busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6_rst");
        exp_q.delete();
        q_flush = 1'b1;
        tick();
        q_flush = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("t6_post");
        b_bt = beat_cyc.size();
        push_cmd(32'h700, 3);
        run_until_idle(50, 0, "t6_recover");
        chk("t6_recover_nbeat", 64'(beat_cyc.size() - b_bt), 64'd3);

        // random bursts with random backpressure
        for (int k = 0; k < 15; k++) begin
            ra = $urandom & 32'hFFFF_FFFC;
            push_cmd(ra, int'($urandom_range(6, 1)));
        end
        run_until_idle(2000, 2, "rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
